// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level line sequencer: START/STOP/WRITE/READ in four quarter-ticks.
// Drives open-drain enables, honours clock stretching, flags arbitration loss.
module i2c_bit_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH_LIM = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic       cmd_bit,
   output logic       done,
   output logic       rd_bit,
   output logic       err,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       scl_i,
   input  logic       sda_i
);

   localparam int SW = $clog2(STRETCH_LIM + 1);
   localparam logic [SW-1:0] LAST = SW'(STRETCH_LIM - 1);

   localparam logic [1:0] C_START = 2'b00;
   localparam logic [1:0] C_STOP  = 2'b01;
   localparam logic [1:0] C_WRITE = 2'b10;
   localparam logic [1:0] C_READ  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_P0,
      S_P1,
      S_P2,
      S_P3
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        cmd_q, cmd_d;
   logic              bit_q, bit_d;
   logic [SW-1:0]     stretch_q, stretch_d;
   logic              arb_q, arb_d;
   logic              hold_q, hold_d;
   logic              rd_bit_q, rd_bit_d;
   logic              scl_oe_q, scl_oe_d;
   logic              sda_oe_q, sda_oe_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              tick_q;
   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;

   logic qtick;
   logic scl_s;
   logic sda_s;

   assign qtick = tick & ~tick_q;
   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   assign cmd_ready = (state_q == S_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign rd_bit    = rd_bit_q;
   assign scl_oe    = scl_oe_q;
   assign sda_oe    = sda_oe_q;

   // Pad synchronisers (idle bus reads high) and tick edge register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         tick_q     <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         tick_q     <= tick;
      end
   end

   // Sequencer state and registered line outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cmd_q     <= C_START;
         bit_q     <= 1'b0;
         stretch_q <= '0;
         arb_q     <= 1'b0;
         hold_q    <= 1'b0;
         rd_bit_q  <= 1'b0;
         scl_oe_q  <= 1'b0;
         sda_oe_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         bit_q     <= bit_d;
         stretch_q <= stretch_d;
         arb_q     <= arb_d;
         hold_q    <= hold_d;
         rd_bit_q  <= rd_bit_d;
         scl_oe_q  <= scl_oe_d;
         sda_oe_q  <= sda_oe_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Phase sequencing, line waveforms, stretch and arbitration handling
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      bit_d     = bit_q;
      stretch_d = stretch_q;
      arb_d     = arb_q;
      hold_d    = hold_q;
      rd_bit_d  = rd_bit_q;
      scl_oe_d  = scl_oe_q;
      sda_oe_d  = sda_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               cmd_d     = cmd;
               bit_d     = cmd_bit;
               arb_d     = 1'b0;
               stretch_d = '0;
               state_d   = S_P0;
               case (cmd)
                  C_START: begin
                     scl_oe_d = 1'b0;
                     sda_oe_d = 1'b0;
                  end
                  C_STOP: begin
                     scl_oe_d = 1'b1;
                     sda_oe_d = 1'b1;
                  end
                  C_WRITE: begin
                     scl_oe_d = 1'b1;
                     sda_oe_d = ~cmd_bit;
                  end
                  default: begin
                     scl_oe_d = 1'b1;
                     sda_oe_d = 1'b0;
                  end
               endcase
            end
         end
         S_P0: begin
            if (qtick) begin
               state_d = S_P1;
               if (cmd_q == C_START) begin
                  sda_oe_d = 1'b1;
               end else begin
                  scl_oe_d = 1'b0;
               end
            end
         end
         S_P1: begin
            if (qtick) begin
               if (scl_s) begin
                  state_d   = S_P2;
                  stretch_d = '0;
                  hold_d    = sda_s;
                  // Only a released SDA can be pulled low by another master
                  if (!sda_s && !sda_oe_q &&
                      ((cmd_q == C_START) ||
                       ((cmd_q == C_WRITE) && bit_q))) begin
                     arb_d = 1'b1;
                  end
                  if (cmd_q == C_START) begin
                     scl_oe_d = 1'b1;
                  end else if (cmd_q == C_STOP) begin
                     sda_oe_d = 1'b0;
                  end
               end else if (stretch_q == LAST) begin
                  state_d   = S_IDLE;
                  stretch_d = '0;
                  scl_oe_d  = 1'b0;
                  sda_oe_d  = 1'b0;
                  done_d    = 1'b1;
                  err_d     = 1'b1;
               end else begin
                  stretch_d = stretch_q + 1'b1;
               end
            end
         end
         S_P2: begin
            if (qtick) begin
               state_d = S_P3;
               if ((cmd_q == C_WRITE) || (cmd_q == C_READ)) begin
                  scl_oe_d = 1'b1;
               end
            end
         end
         S_P3: begin
            if (qtick) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               err_d   = arb_q;
               if (cmd_q == C_READ) begin
                  rd_bit_d = hold_q;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Directed bench for i2c_bit_ctrl with an open-drain pad model
// and a scoreboard of expected done results.
module tb_i2c_bit_ctrl;

   localparam logic [1:0] C_START = 2'b00;
   localparam logic [1:0] C_STOP  = 2'b01;
   localparam logic [1:0] C_WRITE = 2'b10;
   localparam logic [1:0] C_READ  = 2'b11;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick;
   logic [7:0] tcnt = 8'd0;

   logic       cmd_valid = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic       cmd_bit = 1'b0;
   logic       cmd_ready, done, rd_bit, err, scl_oe, sda_oe;
   logic       scl_i, sda_i;
   logic       sl_scl = 1'b0;
   logic       sl_sda = 1'b0;

   logic       cmd_valid2 = 1'b0;
   logic [1:0] cmd2 = 2'b00;
   logic       cmd_bit2 = 1'b0;
   logic       cmd_ready2, done2, rd_bit2, err2, scl_oe2, sda_oe2;
   logic       scl_i2 = 1'b0;
   logic       sda_i2;

   assign tick   = tcnt[2];
   assign scl_i  = ~scl_oe & ~sl_scl;
   assign sda_i  = ~sda_oe & ~sl_sda;
   assign sda_i2 = ~sda_oe2;

   i2c_bit_ctrl #(.SYNC_STAGES(2), .STRETCH_LIM(255)) u_dut (
      .clk(clk), .reset(reset), .tick(tick),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd(cmd), .cmd_bit(cmd_bit),
      .done(done), .rd_bit(rd_bit), .err(err),
      .scl_oe(scl_oe), .sda_oe(sda_oe),
      .scl_i(scl_i), .sda_i(sda_i)
   );

   i2c_bit_ctrl #(.SYNC_STAGES(2), .STRETCH_LIM(4)) u_lim (
      .clk(clk), .reset(reset), .tick(tick),
      .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd(cmd2), .cmd_bit(cmd_bit2),
      .done(done2), .rd_bit(rd_bit2), .err(err2),
      .scl_oe(scl_oe2), .sda_oe(sda_oe2),
      .scl_i(scl_i2), .sda_i(sda_i2)
   );

   always #5 clk = ~clk;

   typedef struct {
      string tag;
      bit    chk_rd;
      logic  rd;
      logic  er;
   } sb_t;

   sb_t sbq[$];

   int ntests = 0;
   int nfail  = 0;
   int qcount = 0;
   int cyc    = 0;
   int done_cnt = 0;
   int dbl    = 0;
   int chg    = 0;
   logic tick_p = 1'b0;
   logic done_p = 1'b0;
   logic sda_p = 1'b0;
   logic scl_p = 1'b0;
   bit   mon_en = 1'b0;

   int q_acc;
   int last_qd;
   int last_t;

   // Free-running timer, quarter-tick counter and done-pulse monitors
   always @(posedge clk) begin
      tcnt   <= tcnt + 8'd1;
      tick_p <= tick;
      if (tick && !tick_p) qcount <= qcount + 1;
      cyc    <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (done && done_p) dbl <= dbl + 1;
      done_p <= done;
   end

   // Count SDA transitions made while SCL was released
   always @(negedge clk) begin
      if (mon_en && (sda_oe !== sda_p) && !scl_p) chg <= chg + 1;
      sda_p <= sda_oe;
      scl_p <= scl_oe;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] c, input logic b,
                        input bit crd, input logic rd, input logic er,
                        input string tag);
      int n;
      sb_t e;
      n = 0;
      while (!cmd_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk({"ready_", tag}, int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd = c;
      cmd_bit = b;
      e.tag = tag;
      e.chk_rd = crd;
      e.rd = rd;
      e.er = er;
      sbq.push_back(e);
      @(negedge clk);
      cmd_valid = 1'b0;
      q_acc = qcount;
      chk({"busy_", tag}, int'(cmd_ready), 0);
   endtask

   task automatic wait_q(input int n);
      int k;
      k = 0;
      while ((qcount - q_acc) < n && k < 400) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic finish_cmd();
      int n;
      sb_t e;
      n = 0;
      while (!done && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", int'(done), 1);
      last_qd = qcount - q_acc;
      last_t = cyc;
      if (sbq.size() == 0) begin
         chk("sb_nonempty", 0, 1);
      end else begin
         e = sbq.pop_front();
         chk({"err_", e.tag}, int'(err), int'(e.er));
         if (e.chk_rd) chk({"rd_", e.tag}, int'(rd_bit), int'(e.rd));
         chk({"ready_at_done_", e.tag}, int'(cmd_ready), 1);
      end
   endtask

   initial begin
      logic [7:0] pat;
      int tds[11];
      int dc0;
      int n;

      // Reset and idle bus
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      chk("idle_done_cnt", done_cnt, 0);
      chk("idle_scl_oe", int'(scl_oe), 0);
      chk("idle_sda_oe", int'(sda_oe), 0);
      chk("idle_ready", int'(cmd_ready), 1);
      chk("idle_rd_bit", int'(rd_bit), 0);
      chk("idle_err", int'(err), 0);

      // START, 0xB2, READ with SDA held low, STOP back-to-back
      dc0 = done_cnt;
      chg = 0;
      mon_en = 1'b1;
      issue(C_START, 1'b0, 1'b0, 1'b0, 1'b0, "start");
      finish_cmd();
      tds[0] = last_t;
      chk("start_scl_oe", int'(scl_oe), 1);
      chk("start_sda_oe", int'(sda_oe), 1);
      pat = 8'hB2;
      for (int i = 0; i < 8; i++) begin
         issue(C_WRITE, pat[7-i], 1'b0, 1'b0, 1'b0, "wr_b2");
         finish_cmd();
         tds[i+1] = last_t;
      end
      sl_sda = 1'b1;
      issue(C_READ, 1'b0, 1'b1, 1'b0, 1'b0, "rd_low");
      finish_cmd();
      tds[9] = last_t;
      sl_sda = 1'b0;
      issue(C_STOP, 1'b0, 1'b0, 1'b0, 1'b0, "stop");
      finish_cmd();
      tds[10] = last_t;
      @(negedge clk);
      mon_en = 1'b0;
      chk("seq_done_cnt", done_cnt - dc0, 11);
      for (int i = 1; i < 11; i++) begin
         chk("seq_interval", tds[i] - tds[i-1], 32);
      end
      chk("sda_chg_scl_high", chg, 2);
      chk("stop_scl_oe", int'(scl_oe), 0);
      chk("stop_sda_oe", int'(sda_oe), 0);
      chk("done_width", dbl, 0);

      // READ of a released line, then WRITE 1 losing arbitration
      issue(C_READ, 1'b0, 1'b1, 1'b1, 1'b0, "rd_high");
      finish_cmd();
      chk("rd_high_qticks", last_qd, 4);
      issue(C_WRITE, 1'b1, 1'b0, 1'b0, 1'b1, "wr_arb");
      wait_q(1);
      sl_sda = 1'b1;
      finish_cmd();
      sl_sda = 1'b0;

      // Slave stretches SCL for 10 quarter-ticks
      issue(C_WRITE, 1'b0, 1'b0, 1'b0, 1'b0, "wr_stretch");
      wait_q(1);
      sl_scl = 1'b1;
      wait_q(11);
      sl_scl = 1'b0;
      finish_cmd();
      chk("stretch_qticks", last_qd, 14);

      // Stretch timeout on the small-limit instance
      n = 0;
      while (!cmd_ready2 && n < 400) begin
         @(negedge clk);
         n++;
      end
      cmd_valid2 = 1'b1;
      cmd2 = C_WRITE;
      cmd_bit2 = 1'b0;
      @(negedge clk);
      cmd_valid2 = 1'b0;
      q_acc = qcount;
      wait_q(1);
      chk("lim_p1_sda_oe", int'(sda_oe2), 1);
      n = 0;
      while (!done2 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("lim_done", int'(done2), 1);
      chk("lim_err", int'(err2), 1);
      chk("lim_scl_oe", int'(scl_oe2), 0);
      chk("lim_sda_oe", int'(sda_oe2), 0);
      chk("lim_ready", int'(cmd_ready2), 1);
      chk("lim_qticks", qcount - q_acc, 5);

      // Reset in the middle of a WRITE
      issue(C_WRITE, 1'b0, 1'b0, 1'b0, 1'b0, "wr_rst");
      wait_q(2);
      @(negedge clk);
      chk("pre_rst_sda_oe", int'(sda_oe), 1);
      dc0 = done_cnt;
      #1;
      reset = 1'b1;
      #1;
      chk("rst_scl_oe", int'(scl_oe), 0);
      chk("rst_sda_oe", int'(sda_oe), 0);
      sbq.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_no_done", done_cnt - dc0, 0);
      chk("rst_ready", int'(cmd_ready), 1);
      issue(C_START, 1'b0, 1'b0, 1'b0, 1'b0, "start_rst");
      finish_cmd();
      chk("start_rst_qticks", last_qd, 4);
      chk("start_rst_scl_oe", int'(scl_oe), 1);
      chk("start_rst_sda_oe", int'(sda_oe), 1);
      @(negedge clk);
      chk("done_width_end", dbl, 0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

endmodule
